alu_uart_ctrl: RTL and testbench
================================

Name: alu_uart_ctrl

Overview:
- Sequencer between the UART receiver/transmitter and the combinational ALU.
- Collects three received bytes (operand A, operand B, opcode) and drives them onto the ALU inputs.
- After one settle cycle, captures the ALU result and hands it to the UART transmitter with a start pulse.
- Waits for transmit completion, then rearms for the next operand set.

Parameters:
- NB_DATA, 8, width of operands, result and UART byte.
- NB_OP, 6, opcode width; taken from rx byte bits [NB_OP-1:0].

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_data  in  NB_DATA  received byte; valid only while i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse, byte available.
- i_alu_result  in  NB_DATA  combinational ALU output.
- i_tx_done  in  1  one-cycle pulse, transmitter finished its byte.
- o_dato_a  out  NB_DATA  registered operand A to the ALU.
- o_dato_b  out  NB_DATA  registered operand B to the ALU.
- o_operation  out  NB_OP  registered opcode to the ALU.
- o_tx_data  out  NB_DATA  registered result byte to the transmitter.
- o_tx_start  out  1  one-cycle pulse, start transmission.
- o_busy  out  1  high in EXEC, SEND, WAIT_TX.
- o_rx_drop  out  1  one-cycle pulse, received byte discarded.

Behaviour:
- Reset (async, i_reset=1): state=WAIT_A; all outputs 0. Reset mid-sequence discards partially loaded operands.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX. All transitions occur on i_clock rising edges.
- WAIT_A: on i_rx_done, o_dato_a<=i_rx_data; go to WAIT_B.
- WAIT_B: on i_rx_done, o_dato_b<=i_rx_data; go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_operation<=i_rx_data[NB_OP-1:0]; go to EXEC. Bits above NB_OP are ignored.
- EXEC: exactly one cycle; the ALU settles. At the edge ending EXEC: o_tx_data<=i_alu_result; go to SEND.
- SEND: exactly one cycle; o_tx_start=1 only in this cycle; go to WAIT_TX.
- WAIT_TX: hold until i_tx_done; then go to WAIT_A.
- i_tx_done during SEND is honoured: go directly to WAIT_A (no deadlock).
- Latency: if the opcode byte's i_rx_done is high in cycle N, EXEC is cycle N+1 and o_tx_start is high in cycle N+2 with a valid o_tx_data.
- o_dato_a, o_dato_b, o_operation and o_tx_data hold their values until overwritten; they are not cleared after a transaction.
- i_rx_done in EXEC, SEND or WAIT_TX: byte discarded; o_rx_drop pulses in the following cycle; FSM unaffected.
- i_rx_done and i_tx_done in the same WAIT_TX cycle: the byte is dropped (o_rx_drop) and the FSM returns to WAIT_A.
- i_tx_done outside SEND/WAIT_TX: ignored.
- No arithmetic in this block; widths pass through unchanged.

Optional Feature:
- Macro: ALU_UART_CTRL_OPCHECK_EN.
- Defined: in WAIT_OP, an opcode not in {0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR}:
  - o_operation is not updated; the FSM returns to WAIT_A; no EXEC/SEND occurs;
  - extra output port o_op_err (1 bit, reset 0) pulses for one cycle in the following cycle.
- Undefined: any NB_OP-bit opcode is forwarded; the o_op_err port does not exist.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD=6'h20, OP_SUB=6'h22, OP_AND=6'h24, OP_OR=6'h25, OP_XOR=6'h26, OP_NOR=6'h27;
  - default widths NB_DATA/NB_OP;
  - FSM state encoding (one-hot, 6 bits).
- The ALU reuses the same opcode constants.
- No sub-module needed. The opcode validity check is a package function (is_valid_op) used under the macro.

Test Plan:
- ADD: rx 0x05, 0x03, 0x20 with an ALU model attached -> o_tx_start pulse 2 cycles after the opcode byte, o_tx_data=0x08; after i_tx_done, o_busy=0 and state WAIT_A.
- SUB wrap: rx 0x03, 0x05, 0x22 -> o_tx_data=0xFE.
- NOR: rx 0x0F, 0xF0, 0x27 -> o_tx_data=0x00.
- Rx during WAIT_TX: rx 0xAA while busy -> o_rx_drop pulse; o_dato_a unchanged; next sequence 0x01, 0x01, 0x24 -> 0x01.
- Reset mid-operation: after A=0x11 and B=0x22, assert i_reset for 1 cycle -> all outputs 0, state WAIT_A; next three bytes load as A, B, OP.
- With ALU_UART_CTRL_OPCHECK_EN: rx 0x01, 0x02, 0x3F -> o_op_err pulse, no o_tx_start, o_operation keeps its prior value. Without the macro: o_operation=0x3F and o_tx_start pulses.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode constants, sequencer state
// encoding and the opcode validity helper used when ALU_UART_CTRL_OPCHECK_EN is set.
package alu_pkg;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;

    localparam logic [NB_OP-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OP-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OP-1:0] OP_AND = 6'h24;
    localparam logic [NB_OP-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OP-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OP-1:0] OP_NOR = 6'h27;

    typedef enum logic [5:0] {
        ST_WAIT_A  = 6'b000001,
        ST_WAIT_B  = 6'b000010,
        ST_WAIT_OP = 6'b000100,
        ST_EXEC    = 6'b001000,
        ST_SEND    = 6'b010000,
        ST_WAIT_TX = 6'b100000
    } state_t;

    function automatic logic is_valid_op(input logic [NB_OP-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// Bundle between the sequencer and its UART/ALU neighbours; names follow the
// sequencer's view (i_ = into the sequencer). o_op_err exists only with ALU_UART_CTRL_OPCHECK_EN.
interface alu_uart_ctrl_if #(
    parameter int NB_DATA = alu_pkg::NB_DATA,
    parameter int NB_OP   = alu_pkg::NB_OP
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_dato_a;
    logic [NB_DATA-1:0] o_dato_b;
    logic [NB_OP-1:0]   o_operation;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_rx_drop;
`ifdef ALU_UART_CTRL_OPCHECK_EN
    logic               o_op_err;
`endif

    modport master (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_dato_a, o_dato_b, o_operation, o_tx_data, o_tx_start, o_busy, o_rx_drop
`ifdef ALU_UART_CTRL_OPCHECK_EN
        , output o_op_err
`endif
    );

    modport slave (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_dato_a, o_dato_b, o_operation, o_tx_data, o_tx_start, o_busy, o_rx_drop
`ifdef ALU_UART_CTRL_OPCHECK_EN
        , input o_op_err
`endif
    );

endinterface

// File: rtl/alu_uart_ctrl_core.sv
// Sequencer FSM: collects A, B, opcode from the UART, lets the ALU settle one
// cycle, then sends the result. ALU_UART_CTRL_OPCHECK_EN rejects unknown opcodes.
module alu_uart_ctrl_core #(
    parameter int NB_DATA = alu_pkg::NB_DATA,
    parameter int NB_OP   = alu_pkg::NB_OP
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    alu_uart_ctrl_if.master      bus
);
    import alu_pkg::*;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load_a;
    logic               w_load_b;
    logic               w_load_op;
    logic               w_op_err;
    logic               w_busy;
    logic [NB_DATA-1:0] r_dato_a;
    logic [NB_DATA-1:0] r_dato_b;
    logic [NB_OP-1:0]   r_operation;
    logic [NB_DATA-1:0] r_tx_data;
    logic               r_rx_drop;

    // NOTE: non-blocking (<=) for every register so all flops sample pre-edge values together.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= ST_WAIT_A;
        else         r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_load_op    = 1'b0;
        w_op_err     = 1'b0;
        unique case (r_state)
            ST_WAIT_A:  if (bus.i_rx_done) begin w_load_a = 1'b1; w_next_state = ST_WAIT_B;  end
            ST_WAIT_B:  if (bus.i_rx_done) begin w_load_b = 1'b1; w_next_state = ST_WAIT_OP; end
            ST_WAIT_OP: if (bus.i_rx_done) begin
`ifdef ALU_UART_CTRL_OPCHECK_EN
                if (is_valid_op(bus.i_rx_data[NB_OP-1:0])) begin
                    w_load_op    = 1'b1;
                    w_next_state = ST_EXEC;
                end else begin
                    w_op_err     = 1'b1;
                    w_next_state = ST_WAIT_A;
                end
`else
                w_load_op    = 1'b1;
                w_next_state = ST_EXEC;
`endif
            end
            ST_EXEC:    w_next_state = ST_SEND;
            // A completion seen already in SEND must not be lost, or WAIT_TX would hang.
            ST_SEND:    w_next_state = bus.i_tx_done ? ST_WAIT_A : ST_WAIT_TX;
            ST_WAIT_TX: if (bus.i_tx_done) w_next_state = ST_WAIT_A;
            default:    w_next_state = ST_WAIT_A;
        endcase
    end

    assign w_busy = (r_state == ST_EXEC) || (r_state == ST_SEND) || (r_state == ST_WAIT_TX);

    // NOTE: these are a handful of flops, not a memory, so all of them take the reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_dato_a    <= '0;
            r_dato_b    <= '0;
            r_operation <= '0;
            r_tx_data   <= '0;
            r_rx_drop   <= 1'b0;
        end else begin
            if (w_load_a)             r_dato_a    <= bus.i_rx_data;
            if (w_load_b)             r_dato_b    <= bus.i_rx_data;
            if (w_load_op)            r_operation <= bus.i_rx_data[NB_OP-1:0];
            if (r_state == ST_EXEC)   r_tx_data   <= bus.i_alu_result;
            r_rx_drop <= bus.i_rx_done && w_busy;
        end
    end

`ifdef ALU_UART_CTRL_OPCHECK_EN
    logic r_op_err;
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_op_err <= 1'b0;
        else         r_op_err <= w_op_err;
    end
    assign bus.o_op_err = r_op_err;
`endif

    assign bus.o_dato_a    = r_dato_a;
    assign bus.o_dato_b    = r_dato_b;
    assign bus.o_operation = r_operation;
    assign bus.o_tx_data   = r_tx_data;
    assign bus.o_tx_start  = (r_state == ST_SEND);
    assign bus.o_busy      = w_busy;
    assign bus.o_rx_drop   = r_rx_drop;

endmodule

// File: rtl/alu_uart_ctrl.sv
// Top: flat UART/ALU pins mapped onto the sequencer bundle.
// Optional opcode filter and o_op_err port: define ALU_UART_CTRL_OPCHECK_EN.
module alu_uart_ctrl #(
    parameter int NB_DATA = alu_pkg::NB_DATA,
    parameter int NB_OP   = alu_pkg::NB_OP
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_dato_a,
    output logic [NB_DATA-1:0] o_dato_b,
    output logic [NB_OP-1:0]   o_operation,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
`ifdef ALU_UART_CTRL_OPCHECK_EN
    output logic               o_op_err,
`endif
    output logic               o_rx_drop
);

    alu_uart_ctrl_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_bus ();

    assign u_bus.i_rx_data    = i_rx_data;
    assign u_bus.i_rx_done    = i_rx_done;
    assign u_bus.i_alu_result = i_alu_result;
    assign u_bus.i_tx_done    = i_tx_done;

    alu_uart_ctrl_core #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_core (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (u_bus.master)
    );

    assign o_dato_a    = u_bus.o_dato_a;
    assign o_dato_b    = u_bus.o_dato_b;
    assign o_operation = u_bus.o_operation;
    assign o_tx_data   = u_bus.o_tx_data;
    assign o_tx_start  = u_bus.o_tx_start;
    assign o_busy      = u_bus.o_busy;
    assign o_rx_drop   = u_bus.o_rx_drop;
`ifdef ALU_UART_CTRL_OPCHECK_EN
    assign o_op_err    = u_bus.o_op_err;
`endif

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl with a small ALU model on i_alu_result.
// Inputs change and outputs are sampled on falling edges; the DUT acts on rising edges.
module tb_alu_uart_ctrl;
    import alu_pkg::*;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    always #5 i_clock = ~i_clock;

    alu_uart_ctrl_if bus ();

    int n_total = 0;
    int n_bad   = 0;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result = alu_model(bus.o_dato_a, bus.o_dato_b, bus.o_operation);

    alu_uart_ctrl dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_data    (bus.i_rx_data),
        .i_rx_done    (bus.i_rx_done),
        .i_alu_result (bus.i_alu_result),
        .i_tx_done    (bus.i_tx_done),
        .o_dato_a     (bus.o_dato_a),
        .o_dato_b     (bus.o_dato_b),
        .o_operation  (bus.o_operation),
        .o_tx_data    (bus.o_tx_data),
        .o_tx_start   (bus.o_tx_start),
        .o_busy       (bus.o_busy),
`ifdef ALU_UART_CTRL_OPCHECK_EN
        .o_op_err     (bus.o_op_err),
`endif
        .o_rx_drop    (bus.o_rx_drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(negedge i_clock);
        bus.i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        bus.i_tx_done = 1'b1;
        @(negedge i_clock);
        bus.i_tx_done = 1'b0;
    endtask

    task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        send_byte(b);
        send_byte(op);
    endtask

    // Entered in EXEC (cycle after the opcode byte); leaves in WAIT_TX.
    task automatic expect_exec(input string tag, input logic [7:0] res);
        check({tag, " exec busy"}, 32'(bus.o_busy), 32'd1);
        check({tag, " exec start"}, 32'(bus.o_tx_start), 32'd0);
        @(negedge i_clock);
        check({tag, " send start"}, 32'(bus.o_tx_start), 32'd1);
        check({tag, " tx_data"}, 32'(bus.o_tx_data), 32'(res));
        @(negedge i_clock);
        check({tag, " wait start"}, 32'(bus.o_tx_start), 32'd0);
        check({tag, " wait busy"}, 32'(bus.o_busy), 32'd1);
    endtask

    initial begin
        bus.i_rx_data = '0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        repeat (2) @(negedge i_clock);
        check("rst dato_a", 32'(bus.o_dato_a), 32'h0);
        check("rst dato_b", 32'(bus.o_dato_b), 32'h0);
        check("rst op", 32'(bus.o_operation), 32'h0);
        check("rst tx_data", 32'(bus.o_tx_data), 32'h0);
        check("rst start", 32'(bus.o_tx_start), 32'h0);
        check("rst busy", 32'(bus.o_busy), 32'h0);
        check("rst drop", 32'(bus.o_rx_drop), 32'h0);
        i_reset = 1'b0;
        @(negedge i_clock);

        // ADD with latency check
        load3(8'h05, 8'h03, 8'h20);
        check("add a", 32'(bus.o_dato_a), 32'h05);
        check("add b", 32'(bus.o_dato_b), 32'h03);
        check("add op", 32'(bus.o_operation), 32'h20);
        expect_exec("add", 8'h08);
        pulse_tx_done();
        check("add idle", 32'(bus.o_busy), 32'd0);

        load3(8'h03, 8'h05, 8'h22);
        expect_exec("sub", 8'hFE);
        pulse_tx_done();

        // NOR, then a stray byte while waiting for the transmitter
        load3(8'h0F, 8'hF0, 8'h27);
        expect_exec("nor", 8'h00);
        send_byte(8'hAA);
        check("drop pulse", 32'(bus.o_rx_drop), 32'd1);
        check("drop a kept", 32'(bus.o_dato_a), 32'h0F);
        check("drop busy", 32'(bus.o_busy), 32'd1);
        @(negedge i_clock);
        check("drop end", 32'(bus.o_rx_drop), 32'd0);
        pulse_tx_done();
        check("nor idle", 32'(bus.o_busy), 32'd0);
        load3(8'h01, 8'h01, 8'h24);
        check("and a", 32'(bus.o_dato_a), 32'h01);
        expect_exec("and", 8'h01);
        pulse_tx_done();

        // tx_done arriving in SEND goes straight back to WAIT_A
        load3(8'h02, 8'h03, 8'h25);
        check("or exec start", 32'(bus.o_tx_start), 32'd0);
        @(negedge i_clock);
        check("or send start", 32'(bus.o_tx_start), 32'd1);
        check("or tx_data", 32'(bus.o_tx_data), 32'h03);
        pulse_tx_done();
        check("or early done", 32'(bus.o_busy), 32'd0);

        // rx and tx done together in WAIT_TX
        load3(8'h04, 8'h04, 8'h26);
        expect_exec("xor", 8'h00);
        bus.i_tx_done = 1'b1;
        send_byte(8'h55);
        bus.i_tx_done = 1'b0;
        check("both drop", 32'(bus.o_rx_drop), 32'd1);
        check("both idle", 32'(bus.o_busy), 32'd0);
        check("both a kept", 32'(bus.o_dato_a), 32'h04);

        // tx_done while idle is ignored; opcode upper bits are stripped
        pulse_tx_done();
        check("stray done idle", 32'(bus.o_busy), 32'd0);
        load3(8'h07, 8'h01, 8'hE2);
        check("strip op", 32'(bus.o_operation), 32'h22);
        expect_exec("strip", 8'h06);
        pulse_tx_done();

        // reset mid-sequence
        send_byte(8'h11);
        send_byte(8'h22);
        check("mid a", 32'(bus.o_dato_a), 32'h11);
        check("mid b", 32'(bus.o_dato_b), 32'h22);
        i_reset = 1'b1;
        #1;
        check("mid rst a", 32'(bus.o_dato_a), 32'h0);
        check("mid rst b", 32'(bus.o_dato_b), 32'h0);
        check("mid rst op", 32'(bus.o_operation), 32'h0);
        check("mid rst tx", 32'(bus.o_tx_data), 32'h0);
        @(negedge i_clock);
        i_reset = 1'b0;
        @(negedge i_clock);
        load3(8'h09, 8'h02, 8'h20);
        check("post a", 32'(bus.o_dato_a), 32'h09);
        check("post b", 32'(bus.o_dato_b), 32'h02);
        check("post op", 32'(bus.o_operation), 32'h20);
        expect_exec("post", 8'h0B);
        pulse_tx_done();

        // unsupported opcode 0x3F
        load3(8'h01, 8'h02, 8'h3F);
`ifdef ALU_UART_CTRL_OPCHECK_EN
        check("bad op err", 32'(bus.o_op_err), 32'd1);
        check("bad op kept", 32'(bus.o_operation), 32'h20);
        check("bad op busy", 32'(bus.o_busy), 32'd0);
        @(negedge i_clock);
        check("bad op err end", 32'(bus.o_op_err), 32'd0);
        check("bad op start", 32'(bus.o_tx_start), 32'd0);
        load3(8'h06, 8'h02, 8'h22);
        expect_exec("after bad", 8'h04);
        pulse_tx_done();
`else
        check("any op fwd", 32'(bus.o_operation), 32'h3F);
        expect_exec("any op", 8'h00);
        pulse_tx_done();
`endif
        check("final idle", 32'(bus.o_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
